// File: rtl/text_overlay_sched_pkg.sv
// Shared types and constants for the text overlay scheduler.
package text_overlay_sched_pkg;

  typedef enum logic [2:0] {
    GAME_MODE_LOADING = 3'd0,
    GAME_MODE_MENU    = 3'd1,
    GAME_MODE_PLAY    = 3'd2,
    GAME_MODE_PAUSE   = 3'd3,
    GAME_MODE_OVER    = 3'd4
  } game_mode_t;

  typedef enum logic {
    RUN   = 1'b0,
    BLANK = 1'b1
  } ovl_state_t;

  localparam logic [7:0] TEXT_SPACE = 8'h20;

endpackage

// File: rtl/text_overlay_sched_if.sv
// Layer request bus and font-lookup result bus of the text overlay scheduler.
interface text_overlay_sched_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0][7:0] req_char;
  logic [N_REQ-1:0]      req_blink;
  logic [7:0]            ascii_char;
  logic                  char_valid;
  logic [N_REQ-1:0]      grant;

  modport master (
    output req_valid, req_char, req_blink,
    input  ascii_char, char_valid, grant
  );

  modport slave (
    input  req_valid, req_char, req_blink,
    output ascii_char, char_valid, grant
  );
endinterface

// File: rtl/text_overlay_sched_frame_blink_timer.sv
// Frame-based blink timer: counts frame_start pulses and toggles the phase on wrap.
module frame_blink_timer #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start,
  input  logic clear,
  input  logic hold,
  output logic blink_phase
);
  localparam int CW = $clog2(BLINK_FRAMES + 1);

  logic [CW-1:0] cnt;

  // clear restarts a visible half-period; hold parks the counter at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      blink_phase <= 1'b1;
    end else if (clear) begin
      cnt         <= '0;
      blink_phase <= 1'b1;
    end else if (hold) begin
      cnt <= '0;
    end else if (frame_start) begin
      if (cnt == CW'(BLINK_FRAMES - 1)) begin
        cnt         <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/text_overlay_sched.sv
// Fixed-priority text layer arbiter with mode-change blanking FSM.
// Optional blinking is enabled by defining TEXT_OVERLAY_BLINK_EN.
module text_overlay_sched
  import text_overlay_sched_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int BLINK_FRAMES = 30,
  parameter int BLANK_FRAMES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_start,
  input  game_mode_t           MODE,
  text_overlay_sched_if.slave  bus,
  output logic                 blink_phase,
  output logic                 blanking
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BW = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;
  localparam logic [N_REQ-1:0] ONE = 1;

  ovl_state_t     state;
  game_mode_t     prev_mode;
  logic [BW-1:0]  blank_cnt;
  logic [IW-1:0]  win;
  logic           any;
  logic           masked;
  logic           mode_chg;
  logic           blank_next;
  logic [N_REQ-1:0] win_oh;

  assign mode_chg = (MODE != prev_mode);
  assign win_oh   = ONE << win;
  assign blanking = (state == BLANK);

  // later indices overwrite earlier ones, so the highest valid layer wins
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (bus.req_valid[i]) begin
        win = IW'(i);
        any = 1'b1;
      end
    end
  end

`ifdef TEXT_OVERLAY_BLINK_EN
  frame_blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .clear       (mode_chg),
    .hold        (state == BLANK),
    .blink_phase (blink_phase)
  );
  // a hidden blinking winner still owns the pixel; lower layers stay masked
  assign masked = bus.req_blink[win] && !blink_phase;
`else
  logic unused_blink;
  assign unused_blink = ^bus.req_blink;
  assign blink_phase  = 1'b1;
  assign masked       = 1'b0;
`endif

  // mode change beats a coincident frame_start, so it reloads instead of exiting
  always_comb begin
    blank_next = 1'b0;
    case (state)
      RUN:   blank_next = mode_chg && (BLANK_FRAMES > 0);
      BLANK: blank_next = mode_chg || !(frame_start && blank_cnt == BW'(1));
      default: blank_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      prev_mode      <= GAME_MODE_LOADING;
      blank_cnt      <= '0;
      bus.ascii_char <= TEXT_SPACE;
      bus.char_valid <= 1'b0;
      bus.grant      <= '0;
    end else begin
      prev_mode <= MODE;
      state     <= blank_next ? BLANK : RUN;

      if (mode_chg && (BLANK_FRAMES > 0))
        blank_cnt <= BW'(BLANK_FRAMES);
      else if (state == BLANK && frame_start)
        blank_cnt <= blank_cnt - 1'b1;

      // outputs follow the state being entered, so blanking shows without lag
      if (blank_next || !any) begin
        bus.ascii_char <= TEXT_SPACE;
        bus.char_valid <= 1'b0;
        bus.grant      <= '0;
      end else if (masked) begin
        bus.ascii_char <= TEXT_SPACE;
        bus.char_valid <= 1'b0;
        bus.grant      <= win_oh;
      end else begin
        bus.ascii_char <= bus.req_char[win];
        bus.char_valid <= 1'b1;
        bus.grant      <= win_oh;
      end
    end
  end
endmodule

// File: tb/tb_text_overlay_sched.sv
// Self-checking bench for text_overlay_sched against a frame-level reference model.
module tb_text_overlay_sched;
  import text_overlay_sched_pkg::*;

  localparam int N = 4, BLINK = 2, BLANK_F = 3;

  logic       clk = 1'b0, rst_n = 1'b0, frame_start = 1'b0;
  game_mode_t mode = GAME_MODE_LOADING;
  logic       blink_phase, blanking;
  int ncmp = 0, nfail = 0;

  text_overlay_sched_if #(.N_REQ(N)) bus ();

  text_overlay_sched #(.N_REQ(N), .BLINK_FRAMES(BLINK), .BLANK_FRAMES(BLANK_F)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .MODE(mode),
    .bus(bus.slave), .blink_phase(blink_phase), .blanking(blanking)
  );

  always #5 clk = ~clk;

  // reference model: frames remaining in blank, frames into the blink half-period
  bit         m_blank, m_phase;
  int         m_left, m_bcnt;
  game_mode_t m_prev;
  logic [7:0] e_char;
  bit         e_cv;
  logic [3:0] e_grant;

  localparam logic [14:0] RST_VEC = {8'h20, 1'b0, 4'b0000, 1'b1, 1'b0};

  function automatic logic [14:0] dut_vec();
    return {bus.ascii_char, bus.char_valid, bus.grant, blink_phase, blanking};
  endfunction

  function automatic logic [14:0] model_vec();
    return {e_char, e_cv, e_grant, m_phase, m_blank};
  endfunction

  task automatic model_reset();
    m_blank = 0; m_phase = 1; m_left = 0; m_bcnt = 0; m_prev = GAME_MODE_LOADING;
    e_char = 8'h20; e_cv = 0; e_grant = 0;
  endtask

  task automatic model_step();
    bit chg, was_blank, old_phase, hidden;
    int w;
    chg = (mode != m_prev); was_blank = m_blank; old_phase = m_phase; w = -1; hidden = 0;
    m_prev = mode;
    if (chg) begin
      if (BLANK_F > 0) begin m_blank = 1; m_left = BLANK_F; end
    end else if (m_blank && frame_start) begin
      m_left--;
      if (m_left == 0) m_blank = 0;
    end
`ifdef TEXT_OVERLAY_BLINK_EN
    if (chg) begin m_bcnt = 0; m_phase = 1; end
    else if (was_blank) m_bcnt = 0;
    else if (frame_start) begin
      m_bcnt++;
      if (m_bcnt == BLINK) begin m_bcnt = 0; m_phase = !m_phase; end
    end
`else
    if (was_blank) m_bcnt = 0;
`endif
    for (int i = N - 1; i >= 0; i--) if (bus.req_valid[i]) begin w = i; break; end
    e_char = 8'h20; e_cv = 0; e_grant = 0;
    if (!m_blank && w >= 0) begin
      e_grant[w] = 1'b1;
`ifdef TEXT_OVERLAY_BLINK_EN
      hidden = bus.req_blink[w] && !old_phase;
`endif
      if (!hidden) begin e_char = bus.req_char[w]; e_cv = 1; end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pulse();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid = '0; bus.req_blink = '0; bus.req_char = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    if (dut_vec() !== RST_VEC) begin
      nfail++; $display("FAIL reset_state got=%h want=%h", dut_vec(), RST_VEC);
    end
    ncmp++;
    rst_n = 1'b1;
  endtask

  task automatic test_priority();
    logic [14:0] exp [4];
    logic [3:0]  vin [4];
    vin = '{4'b0101, 4'b0000, 4'b1111, 4'b0001};
    exp = '{{8'h43, 1'b1, 4'b0100, 1'b1, 1'b0}, {8'h20, 1'b0, 4'b0000, 1'b1, 1'b0},
            {8'h44, 1'b1, 4'b1000, 1'b1, 1'b0}, {8'h41, 1'b1, 4'b0001, 1'b1, 1'b0}};
    bus.req_char = {8'h44, 8'h43, 8'h42, 8'h41};
    for (int k = 0; k < 4; k++) begin
      bus.req_valid = vin[k];
      tick();
      if (dut_vec() !== exp[k]) begin
        nfail++; $display("FAIL priority[%0d] got=%h want=%h", k, dut_vec(), exp[k]);
      end
      ncmp++;
    end
  endtask

  task automatic test_blank();
    bus.req_valid = 4'b0101;
    mode = GAME_MODE_MENU; tick();
    if (dut_vec() !== {8'h20, 1'b0, 4'b0000, 1'b1, 1'b1}) begin
      nfail++; $display("FAIL blank_entry got=%h want=%h", dut_vec(), {8'h20, 1'b0, 4'b0000, 1'b1, 1'b1});
    end
    ncmp++;
    for (int p = 1; p <= 3; p++) begin
      tick(); pulse();
      if (blanking !== (p < 3)) begin
        nfail++; $display("FAIL blank_pulse%0d got=%b want=%b", p, blanking, p < 3);
      end
      ncmp++;
    end
    tick();
    if (dut_vec() !== {8'h43, 1'b1, 4'b0100, 1'b1, 1'b0}) begin
      nfail++; $display("FAIL blank_exit got=%h want=%h", dut_vec(), {8'h43, 1'b1, 4'b0100, 1'b1, 1'b0});
    end
    ncmp++;
    // second mode change after pulse 2 extends by a full period
    mode = GAME_MODE_PLAY; tick();
    pulse(); tick(); pulse();
    mode = GAME_MODE_MENU; tick();
    for (int p = 1; p <= 3; p++) begin
      tick(); pulse();
      if (blanking !== (p < 3)) begin
        nfail++; $display("FAIL extend_pulse%0d got=%b want=%b", p, blanking, p < 3);
      end
      ncmp++;
    end
    tick();
  endtask

  task automatic test_coincident();
    mode = GAME_MODE_PAUSE; tick();
    pulse(); pulse();
    mode = GAME_MODE_OVER; frame_start = 1'b1; tick(); frame_start = 1'b0;
    if (blanking !== 1'b1) begin
      nfail++; $display("FAIL coincident_reload got=%b want=1", blanking);
    end
    ncmp++;
    for (int p = 1; p <= 3; p++) begin
      pulse();
      if (blanking !== (p < 3)) begin
        nfail++; $display("FAIL coincident_pulse%0d got=%b want=%b", p, blanking, p < 3);
      end
      ncmp++;
    end
  endtask

  task automatic test_blink();
    bit          fs  [7];
    logic [14:0] exp [7];
    fs = '{0, 1, 1, 0, 1, 1, 0};
`ifdef TEXT_OVERLAY_BLINK_EN
    exp = '{{8'h44, 1'b1, 4'b1000, 1'b1, 1'b0}, {8'h44, 1'b1, 4'b1000, 1'b1, 1'b0},
            {8'h44, 1'b1, 4'b1000, 1'b0, 1'b0}, {8'h20, 1'b0, 4'b1000, 1'b0, 1'b0},
            {8'h20, 1'b0, 4'b1000, 1'b0, 1'b0}, {8'h20, 1'b0, 4'b1000, 1'b1, 1'b0},
            {8'h44, 1'b1, 4'b1000, 1'b1, 1'b0}};
`else
    for (int k = 0; k < 7; k++) exp[k] = {8'h44, 1'b1, 4'b1000, 1'b1, 1'b0};
`endif
    bus.req_valid = 4'b1100; bus.req_blink = 4'b1000;
    bus.req_char  = {8'h44, 8'h43, 8'h42, 8'h41};
    for (int k = 0; k < 7; k++) begin
      frame_start = fs[k]; tick(); frame_start = 1'b0;
      if (dut_vec() !== exp[k]) begin
        nfail++; $display("FAIL blink[%0d] got=%h want=%h", k, dut_vec(), exp[k]);
      end
      ncmp++;
    end
    bus.req_blink = '0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      bus.req_valid = 4'($urandom);
      bus.req_blink = 4'($urandom);
      for (int i = 0; i < N; i++) bus.req_char[i] = 8'($urandom_range(33, 126));
      frame_start = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 24) == 0) mode = game_mode_t'($urandom_range(0, 4));
      tick();
      if (dut_vec() !== model_vec()) begin
        nfail++; $display("FAIL random[%0d] got=%h want=%h", k, dut_vec(), model_vec());
      end
      ncmp++;
    end
    frame_start = 1'b0;
  endtask

  task automatic test_reset_mid();
    mode = (mode == GAME_MODE_PLAY) ? GAME_MODE_MENU : GAME_MODE_PLAY;
    bus.req_valid = 4'b0010; bus.req_blink = '0;
    bus.req_char  = {8'h44, 8'h43, 8'h42, 8'h41};
    tick();
    if (blanking !== 1'b1) begin
      nfail++; $display("FAIL pre_reset_blank got=%b want=1", blanking);
    end
    ncmp++;
    #3 rst_n = 1'b0;
    #1;
    if (dut_vec() !== RST_VEC) begin
      nfail++; $display("FAIL reset_mid_blank got=%h want=%h", dut_vec(), RST_VEC);
    end
    ncmp++;
    mode = GAME_MODE_LOADING;
    @(posedge clk); #1;
    rst_n = 1'b1; model_reset();
    tick();
    if (dut_vec() !== {8'h42, 1'b1, 4'b0010, 1'b1, 1'b0}) begin
      nfail++; $display("FAIL post_reset got=%h want=%h", dut_vec(), {8'h42, 1'b1, 4'b0010, 1'b1, 1'b0});
    end
    ncmp++;
    #3 rst_n = 1'b0;
    #1;
    if (dut_vec() !== RST_VEC) begin
      nfail++; $display("FAIL reset_mid_arb got=%h want=%h", dut_vec(), RST_VEC);
    end
    ncmp++;
    @(posedge clk); #1;
    rst_n = 1'b1; model_reset();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_blank();
    test_coincident();
    test_blink();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/text_overlay_sched.md
TEXT_OVERLAY_SCHED -- requirements
Module: text_overlay_sched

Interface
REQ-001 Parameter N_REQ, default 4: number of text layers sharing the single font lookup.
REQ-002 Parameter BLINK_FRAMES, default 30: frames per blink half-period.
REQ-003 Parameter BLANK_FRAMES, default 8: frames of forced blank after a mode change; 0 disables blanking.
REQ-004 clk  in  1  system clock; one clock for the whole block.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 frame_start  in  1  one-cycle strobe at the first pixel of each frame.
REQ-007 MODE  in  game_mode_t  current game mode.
REQ-008 req_valid  in  N_REQ  per-layer flag: the layer covers the current pixel.
REQ-009 req_char  in  N_REQ x 8  per-layer ASCII code for the current pixel.
REQ-010 req_blink  in  N_REQ  per-layer flag: the layer is subject to blinking.
REQ-011 ascii_char  out  8  registered character to the font lookup.
REQ-012 char_valid  out  1  ascii_char carries a visible layer character.
REQ-013 grant  out  N_REQ  one-hot winning layer; all zero when none wins.
REQ-014 blink_phase  out  1  1 = blinking layers visible.
REQ-015 blanking  out  1  1 while in the BLANK state.

Function
REQ-016 Arbitration is fixed priority; the highest index with req_valid set wins (layer N_REQ-1 is highest).
REQ-017 Outputs are registered, so inputs sampled at cycle n appear at cycle n+1 (latency 1).
REQ-018 When no layer is valid: ascii_char = 0x20 (space), char_valid = 0, grant = 0.
REQ-019 When the winner has req_blink=1 and blink_phase=0: grant shows the winner, ascii_char = 0x20, char_valid = 0, and lower layers are masked, not shown through.
REQ-020 Blink counter: 0..BLINK_FRAMES-1, increments on frame_start; on wrap to 0 it toggles blink_phase.
REQ-021 FSM states are RUN and BLANK.
REQ-022 RUN to BLANK: MODE differs from the registered previous MODE and BLANK_FRAMES>0; load blank_cnt=BLANK_FRAMES, clear the blink counter, set blink_phase=1.
REQ-023 In BLANK: ascii_char=0x20, char_valid=0, grant=0, blanking=1; blank_cnt decrements on frame_start.
REQ-024 BLANK to RUN: frame_start while blank_cnt==1; the transition takes effect the next cycle.
REQ-025 A mode change during BLANK reloads blank_cnt=BLANK_FRAMES and stays in BLANK.
REQ-026 A mode change and frame_start in the same cycle: the mode change wins; reload with no decrement.
REQ-027 With BLANK_FRAMES=0, a mode change only clears the blink counter and sets blink_phase=1; the FSM stays in RUN.
REQ-028 The blink counter is held at 0 while in BLANK.

Reset
REQ-029 rst_n low asynchronously forces: state=RUN, ascii_char=0x20, char_valid=0, grant=0, blink_phase=1, blanking=0, counters=0, previous-MODE register=MODE reset value (GAME_MODE_LOADING).
REQ-030 Deassertion is synchronous to clk, and the first sampled inputs produce outputs one cycle later.
REQ-031 Reset mid-BLANK returns to RUN without completing the blank period.

Configuration
REQ-032 Macro TEXT_OVERLAY_BLINK_EN defined: blink counter and masking per REQ-019/020 are present.
REQ-033 Macro TEXT_OVERLAY_BLINK_EN undefined: blink counter is absent, blink_phase is tied 1, and req_blink is ignored; all other behaviour is unchanged.

Structure
REQ-034 The state enum (RUN, BLANK) and the constant TEXT_SPACE=8'h20 live in the shared defines package alongside game_mode_t.
REQ-035 Sub-module frame_blink_timer holds the blink counter and blink_phase (inputs: clk, rst_n, frame_start, clear, hold); it is instantiated only under TEXT_OVERLAY_BLINK_EN.
REQ-036 The arbiter and FSM stay in text_overlay_sched, with no further hierarchy.

Verification
REQ-037 req_valid=4'b0101, chars 'A','B','C','D' (layer 0 = 'A' through layer 3 = 'D'), no blink -> next cycle ascii_char='C', grant=4'b0100, char_valid=1.
REQ-038 req_valid=0 -> ascii_char=0x20, char_valid=0, grant=0.
REQ-039 BLINK_FRAMES=2, layer 3 blinking and valid, 4 frame_start pulses -> blink_phase toggles after pulses 2 and 4; layer 2 valid is never shown while layer 3 is masked.
REQ-040 BLANK_FRAMES=3, MODE change -> blanking=1 for exactly 3 frame_start pulses, then RUN; a second MODE change after pulse 2 extends the blank to 3 more pulses.
REQ-041 MODE change coincident with frame_start in BLANK -> blank_cnt reloads to 3, with no decrement.
REQ-042 rst_n asserted mid-BLANK and mid-arbitration -> all outputs take their reset values immediately, without waiting for clk.
